// File: rtl/adc_frame_depacketizer_pkg.sv
// Frame format shared by the ADC packetizer and depacketizer.
// Holds the FSM encoding, header field positions and the default sample geometry.
package adc_frame_depacketizer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DROP    = 2'd2
   } state_t;

   // Header word layout; bits [7:4] are reserved.
   localparam int unsigned PORT_MSB = 31;
   localparam int unsigned PORT_LSB = 16;
   localparam int unsigned SEQ_MSB  = 15;
   localparam int unsigned SEQ_LSB  = 8;
   localparam int unsigned EXP_MSB  = 3;
   localparam int unsigned EXP_LSB  = 0;

   localparam int unsigned WORD_W            = 32;
   localparam int unsigned DEF_PAYLOAD_WORDS = 8;
   localparam int unsigned SAMPLE_W          = WORD_W * DEF_PAYLOAD_WORDS;

endpackage

// File: rtl/adc_frame_depacketizer_sat_counter.sv
// Saturating up-counter used for the depacketizer statistics.
// Ports: clock, reset (sync, active-high), inc (count enable), count (holds at all-ones).
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/adc_frame_depacketizer.sv
// Receive-side ADC frame depacketizer: filters frames on destination UDP port,
// checks framing and sequence, and reassembles one sample + exponent per good frame.
// Ports: clock/reset (sync, active-high); validin/sof/eof/datain framed word stream;
//        intudpport local port; adcdatain/adcexpin/adcvalidin delivered sample;
//        seqout/seqerr sequence tracking; frameerr strobe; goodcnt/errcnt/portdropcnt stats.
module adc_frame_depacketizer
   import adc_frame_depacketizer_pkg::*;
#(
   parameter int unsigned PAYLOAD_WORDS = DEF_PAYLOAD_WORDS,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              validin,
   input  logic                              sof,
   input  logic                              eof,
   input  logic [31:0]                       datain,
   input  logic [15:0]                       intudpport,
   output logic [WORD_W*PAYLOAD_WORDS-1:0]   adcdatain,
   output logic [3:0]                        adcexpin,
   output logic                              adcvalidin,
   output logic [7:0]                        seqout,
   output logic                              seqerr,
   output logic                              frameerr,
   output logic [CNT_W-1:0]                  goodcnt,
   output logic [CNT_W-1:0]                  errcnt,
   output logic [CNT_W-1:0]                  portdropcnt
);

   localparam int unsigned SW    = WORD_W * PAYLOAD_WORDS;
   localparam int unsigned IDX_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_WORDS - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [SW-1:0]    shadow;
   logic [SW-1:0]    shift_val;
   logic [7:0]       lat_seq;
   logic [3:0]       lat_exp;
   logic             seq_armed;

   logic port_ok;
   logic hdr_take;
   logic port_drop;
   logic frame_err;
   logic good;
   logic shift_en;

   assign port_ok   = (datain[PORT_MSB:PORT_LSB] == intudpport);
   assign shift_val = {shadow[SW-WORD_W-1:0], datain};

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-word control decode
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      hdr_take  = 1'b0;
      port_drop = 1'b0;
      frame_err = 1'b0;
      good      = 1'b0;
      shift_en  = 1'b0;

      if (validin) begin
         unique case (state)
            ST_IDLE: begin
               if (sof && !eof) begin
                  if (port_ok) begin
                     hdr_take  = 1'b1;
                     idx_nxt   = '0;
                     state_nxt = ST_PAYLOAD;
                  end else begin
                     port_drop = 1'b1;
                     state_nxt = ST_DROP;
                  end
               end else if (sof) begin
                  frame_err = 1'b1;
               end else begin
                  frame_err = 1'b1;
                  state_nxt = ST_DROP;
               end
            end
            ST_PAYLOAD: begin
               if (sof) begin
                  // Abort the current frame; a sof without eof restarts as a header.
                  frame_err = 1'b1;
                  state_nxt = ST_IDLE;
                  if (!eof) begin
                     if (port_ok) begin
                        hdr_take  = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = ST_PAYLOAD;
                     end else begin
                        port_drop = 1'b1;
                        state_nxt = ST_DROP;
                     end
                  end
               end else begin
                  shift_en = 1'b1;
                  idx_nxt  = idx + IDX_W'(1);
                  if (eof) begin
                     state_nxt = ST_IDLE;
                     if (idx == LAST_IDX) begin
                        good = 1'b1;
                     end else begin
                        frame_err = 1'b1;
                     end
                  end else if (idx == LAST_IDX) begin
                     frame_err = 1'b1;
                     state_nxt = ST_DROP;
                  end
               end
            end
            ST_DROP: begin
               if (sof && !eof) begin
                  if (port_ok) begin
                     hdr_take  = 1'b1;
                     idx_nxt   = '0;
                     state_nxt = ST_PAYLOAD;
                  end else begin
                     port_drop = 1'b1;
                  end
               end else if (eof) begin
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         idx        <= '0;
         shadow     <= '0;
         lat_seq    <= '0;
         lat_exp    <= '0;
         seq_armed  <= 1'b0;
         adcdatain  <= '0;
         adcexpin   <= '0;
         adcvalidin <= 1'b0;
         seqout     <= '0;
         seqerr     <= 1'b0;
         frameerr   <= 1'b0;
      end else begin
         idx        <= idx_nxt;
         adcvalidin <= good;
         frameerr   <= frame_err;
         // Sequence check only once a reference frame has been delivered.
         seqerr     <= good && seq_armed && (lat_seq != (seqout + 8'(1)));
         if (shift_en) begin
            shadow <= shift_val;
         end
         if (hdr_take) begin
            lat_seq <= datain[SEQ_MSB:SEQ_LSB];
            lat_exp <= datain[EXP_MSB:EXP_LSB];
         end
         if (good) begin
            adcdatain <= shift_val;
            adcexpin  <= lat_exp;
            seqout    <= lat_seq;
            seq_armed <= 1'b1;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_goodcnt (
      .clock (clock),
      .reset (reset),
      .inc   (good),
      .count (goodcnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_errcnt (
      .clock (clock),
      .reset (reset),
      .inc   (frame_err),
      .count (errcnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_portdropcnt (
      .clock (clock),
      .reset (reset),
      .inc   (port_drop),
      .count (portdropcnt)
   );

endmodule

// File: tb/tb_adc_frame_depacketizer.sv
// Directed self-checking bench for adc_frame_depacketizer.
module tb_adc_frame_depacketizer;

   logic         clock = 1'b0;
   logic         reset;
   logic         validin;
   logic         sof;
   logic         eof;
   logic [31:0]  datain;
   logic [15:0]  intudpport;
   logic [255:0] adcdatain;
   logic [3:0]   adcexpin;
   logic         adcvalidin;
   logic [7:0]   seqout;
   logic         seqerr;
   logic         frameerr;
   logic [15:0]  goodcnt;
   logic [15:0]  errcnt;
   logic [15:0]  portdropcnt;

   int vectors   = 0;
   int miscompares = 0;

   logic [255:0] frame_sample;
   logic [255:0] held_sample;

   always #5 clock = ~clock;

   adc_frame_depacketizer dut (
      .clock       (clock),
      .reset       (reset),
      .validin     (validin),
      .sof         (sof),
      .eof         (eof),
      .datain      (datain),
      .intudpport  (intudpport),
      .adcdatain   (adcdatain),
      .adcexpin    (adcexpin),
      .adcvalidin  (adcvalidin),
      .seqout      (seqout),
      .seqerr      (seqerr),
      .frameerr    (frameerr),
      .goodcnt     (goodcnt),
      .errcnt      (errcnt),
      .portdropcnt (portdropcnt)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic put(input logic s, input logic e, input logic [31:0] d);
      @(negedge clock);
      validin = 1'b1;
      sof     = s;
      eof     = e;
      datain  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         validin = 1'b0;
         sof     = 1'b0;
         eof     = 1'b0;
      end
   endtask

   function automatic logic [31:0] pword(input int k, input logic [31:0] salt);
      return (32'(k) * 32'h1111_1111) ^ salt;
   endfunction

   // Header, then payload words first..last; eof on word 'eof_at' (which ends the burst).
   // Optional idle gap after word 'gap_after'. frame_sample models the shift-in order.
   task automatic send_frame(input logic [15:0] port, input logic [7:0] seq, input logic [3:0] ex,
                             input logic [31:0] salt, input int eof_at, input int gap_after,
                             input int gap_len);
      logic [255:0] s;
      s = '0;
      put(1'b1, 1'b0, {port, seq, 4'hA, ex});
      for (int k = 1; k <= eof_at; k++) begin
         put(1'b0, (k == eof_at), pword(k, salt));
         s = {s[223:0], pword(k, salt)};
         if (k == gap_after) idle(gap_len);
      end
      frame_sample = s;
   endtask

   initial begin
      reset      = 1'b1;
      validin    = 1'b0;
      sof        = 1'b0;
      eof        = 1'b0;
      datain     = '0;
      intudpport = 16'h1F90;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      idle(1);

      // Reset state
      chk("rst_valid", 256'(adcvalidin), 256'(0));
      chk("rst_data", adcdatain, 256'(0));
      chk("rst_exp", 256'(adcexpin), 256'(0));
      chk("rst_seq", 256'(seqout), 256'(0));
      chk("rst_cnts", 256'({goodcnt, errcnt, portdropcnt}), 256'(0));

      // Basic good frame
      send_frame(16'h1F90, 8'h05, 4'h3, 32'h0, 8, 0, 0);
      idle(1);
      chk("t1_valid", 256'(adcvalidin), 256'(1));
      chk("t1_msw", 256'(adcdatain[255:224]), 256'(32'h1111_1111));
      chk("t1_lsw", 256'(adcdatain[31:0]), 256'(32'h8888_8888));
      chk("t1_data", adcdatain, frame_sample);
      chk("t1_exp", 256'(adcexpin), 256'(3));
      chk("t1_seq", 256'(seqout), 256'(5));
      chk("t1_seqerr", 256'(seqerr), 256'(0));
      chk("t1_good", 256'(goodcnt), 256'(1));
      idle(1);
      chk("t1_strobe", 256'(adcvalidin), 256'(0));
      chk("t1_hold", adcdatain, frame_sample);

      // Idle gap mid-frame
      send_frame(16'h1F90, 8'h06, 4'h3, 32'h0, 8, 4, 3);
      chk("t2_pre", 256'(adcvalidin), 256'(0));
      idle(1);
      chk("t2_valid", 256'(adcvalidin), 256'(1));
      chk("t2_data", adcdatain, frame_sample);
      chk("t2_seqerr", 256'(seqerr), 256'(0));
      chk("t2_good", 256'(goodcnt), 256'(2));

      // Port filter, then a good frame with a different payload
      send_frame(16'h1F91, 8'h07, 4'h9, 32'hFFFF_0000, 8, 0, 0);
      idle(1);
      chk("t3_novalid", 256'(adcvalidin), 256'(0));
      chk("t3_drop", 256'(portdropcnt), 256'(1));
      chk("t3_err", 256'(errcnt), 256'(0));
      send_frame(16'h1F90, 8'h07, 4'h9, 32'hA5A5_A5A5, 8, 0, 0);
      idle(1);
      chk("t3_valid", 256'(adcvalidin), 256'(1));
      chk("t3_data", adcdatain, frame_sample);
      chk("t3_exp", 256'(adcexpin), 256'(9));
      chk("t3_seqerr", 256'(seqerr), 256'(0));
      chk("t3_good", 256'(goodcnt), 256'(3));
      held_sample = frame_sample;

      // Early eof
      send_frame(16'h1F90, 8'h08, 4'h1, 32'h0, 5, 0, 0);
      idle(1);
      chk("t4_ferr", 256'(frameerr), 256'(1));
      chk("t4_novalid", 256'(adcvalidin), 256'(0));
      chk("t4_err", 256'(errcnt), 256'(1));
      chk("t4_hold", adcdatain, held_sample);
      chk("t4_exphold", 256'(adcexpin), 256'(9));
      // sof inside a frame aborts it and starts a new one
      put(1'b1, 1'b0, 32'h1F90_0801);
      put(1'b0, 1'b0, 32'hDEAD_0001);
      put(1'b0, 1'b0, 32'hDEAD_0002);
      send_frame(16'h1F90, 8'h08, 4'h2, 32'h0F0F_0F0F, 8, 0, 0);
      idle(1);
      chk("t4_err2", 256'(errcnt), 256'(2));
      chk("t4_valid", 256'(adcvalidin), 256'(1));
      chk("t4_data", adcdatain, frame_sample);
      chk("t4_exp", 256'(adcexpin), 256'(2));
      chk("t4_seqerr", 256'(seqerr), 256'(0));

      // Sequence wrap and gap
      send_frame(16'h1F90, 8'hFF, 4'h4, 32'h0, 8, 0, 0);
      idle(1);
      chk("t5_jump", 256'(seqerr), 256'(1));
      chk("t5_seqff", 256'(seqout), 256'(8'hFF));
      send_frame(16'h1F90, 8'h00, 4'h4, 32'h0, 8, 0, 0);
      idle(1);
      chk("t5_wrap", 256'(seqerr), 256'(0));
      chk("t5_wrapv", 256'(adcvalidin), 256'(1));
      send_frame(16'h1F90, 8'h02, 4'h4, 32'h0, 8, 0, 0);
      idle(1);
      chk("t5_gapv", 256'(adcvalidin), 256'(1));
      chk("t5_gap", 256'(seqerr), 256'(1));
      chk("t5_seq", 256'(seqout), 256'(2));
      chk("t5_good", 256'(goodcnt), 256'(7));

      // Reset mid-frame
      put(1'b1, 1'b0, 32'h1F90_0305);
      for (int k = 1; k <= 3; k++) put(1'b0, 1'b0, pword(k, 32'h0));
      @(negedge clock);
      reset   = 1'b1;
      validin = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      for (int k = 4; k <= 8; k++) put(1'b0, (k == 8), pword(k, 32'h0));
      idle(1);
      chk("t6_err", 256'(errcnt), 256'(1));
      chk("t6_good", 256'(goodcnt), 256'(0));
      chk("t6_novalid", 256'(adcvalidin), 256'(0));
      chk("t6_data", adcdatain, 256'(0));
      send_frame(16'h1F90, 8'h09, 4'h6, 32'h3C3C_3C3C, 8, 0, 0);
      idle(1);
      chk("t6_valid", 256'(adcvalidin), 256'(1));
      chk("t6_seqerr", 256'(seqerr), 256'(0));
      chk("t6_seq", 256'(seqout), 256'(9));
      chk("t6_dat", adcdatain, frame_sample);
      chk("t6_good1", 256'(goodcnt), 256'(1));

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adc_frame_depacketizer.md
Name: adc_frame_depacketizer

Overview:
- Receive-side counterpart of the FPGA1 ADC packetizer. Consumes the framed 32-bit word stream (valid/sof/eof/data) arriving from the link.
- Filters each frame on destination UDP port, checks framing and sequence, and reassembles one 256-bit ADC sample plus 4-bit exponent per good frame.
- Sits between the link receive interface and the downstream ADC-data consumer on the receiving FPGA.

Parameters:
- PAYLOAD_WORDS, 8, number of 32-bit data words after the header; sample width = 32*PAYLOAD_WORDS.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- validin  in  1  input word qualifier.
- sof  in  1  first word of frame; meaningful only with validin.
- eof  in  1  last word of frame; meaningful only with validin.
- datain  in  32  input word.
- intudpport  in  16  local UDP port; frames for any other port are dropped.
- adcdatain  out  256  reassembled sample; word1 lands in [255:224], word8 in [31:0].
- adcexpin  out  4  exponent from the header.
- adcvalidin  out  1  one-cycle strobe: adcdatain/adcexpin updated.
- seqout  out  8  sequence number of the last delivered frame.
- seqerr  out  1  one-cycle strobe with adcvalidin when the sequence number is not last+1 (mod 256).
- frameerr  out  1  one-cycle strobe on any framing error.
- goodcnt, errcnt, portdropcnt  out  CNT_W each  saturating counters: delivered frames, framing errors, port-filtered frames.

Behaviour:
- Header word, accepted with sof: [31:16] destination port, [15:8] sequence number, [7:4] reserved (ignored), [3:0] exponent.
- Words 1..PAYLOAD_WORDS are payload, MSW first. The last payload word must carry eof. Nine words per frame by default.
- Idle cycles (validin=0) are allowed anywhere inside a frame and do not change state.
- States: IDLE, PAYLOAD, DROP.
- IDLE:
  - validin&sof&!eof with port match -> latch seq and exp, clear word index, go to PAYLOAD.
  - validin&sof&!eof with port mismatch -> portdropcnt++, go to DROP.
  - validin&sof&eof (runt) -> frameerr, errcnt++, stay in IDLE.
  - validin without sof -> frameerr, errcnt++, go to DROP.
- PAYLOAD:
  - Each validin word is shifted into the sample shadow register and the index increments.
  - eof at index PAYLOAD_WORDS-1 -> frame good, go to IDLE.
  - eof earlier -> frameerr, errcnt++, go to IDLE, nothing delivered.
  - Word at index PAYLOAD_WORDS-1 without eof -> frameerr, errcnt++, go to DROP.
  - sof while in PAYLOAD -> frameerr, errcnt++, abort the current frame, then treat this word as a new header exactly as in IDLE (port check included).
- DROP:
  - Discard words until validin&eof, then go to IDLE.
  - validin&sof&!eof -> process as a new header as in IDLE. No additional error is counted in DROP.
- Output timing:
  - Good frame: adcdatain, adcexpin and seqout update, and adcvalidin pulses, on the cycle after the eof word is sampled. Latency is one clock.
  - adcdatain and adcexpin hold between frames.
  - Partial or bad frames never disturb the output registers.
- Sequence check: disabled until the first good frame after reset. After that, seqerr is asserted with adcvalidin when seq != seqout+1 (255 wraps to 0). The frame is still delivered and goodcnt still increments.
- Counters saturate at all-ones; they do not wrap.
- Reset values: all outputs 0, state IDLE, index 0, sequence check disabled.
- A reset asserted mid-frame discards the partial frame. The remainder of that frame arrives without sof and is counted as one framing error before DROP resynchronises on eof.
- sof and eof without validin are ignored.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, PAYLOAD, DROP);
  - header field bit positions (PORT_MSB/LSB, SEQ_MSB/LSB, EXP_MSB/LSB);
  - default PAYLOAD_WORDS;
  - sample width constant.
- The packetizer imports the same package so both ends agree on the frame format.
- One sub-module: sat_counter (parameter CNT_W; ports clock, reset, inc, count). Instantiated three times.

Test Plan:
- Port 0x1F90 with intudpport=0x1F90, header 0x1F90_0503, 8 payload words 0x11111111..0x88888888 with eof on the last -> next cycle adcvalidin=1, adcdatain[255:224]=0x11111111, adcdatain[31:0]=0x88888888, adcexpin=3, seqout=5, goodcnt=1.
- Same frame with validin dropped for 3 cycles between words 4 and 5 -> identical output, adcvalidin one cycle after eof.
- Header port 0x1F91 -> no adcvalidin, portdropcnt=1; a following correct frame is delivered normally.
- eof on payload word 5 -> frameerr pulse, errcnt=1, output unchanged; a new sof inside a frame -> errcnt=2, and the new frame is delivered.
- Good frames with seq 0xFF then 0x00 -> no seqerr; then seq 0x02 -> seqerr=1 with adcvalidin.
- reset after word 3 of a frame, then the remaining words -> errcnt=1 after reset, no delivery; the next full frame is delivered with seqerr=0.
